// File: rtl/toggle_sync_rx.sv
// toggle_sync_rx: destination-side toggle CDC receiver; queues each synchronized
// tgl_in transition as an event and returns an ack toggle per accepted event.
module toggle_sync_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_DEPTH  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgl_in,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic             ack_tgl,
    output logic             overrun,
    output logic [3:0]       pend_cnt,
    output logic [CNT_W-1:0] evt_cnt
);
    localparam logic [2:0] GUARD_MAX = 3'(SYNC_STAGES + 1);
    localparam logic [3:0] PEND_MAX  = 4'(PEND_DEPTH);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_tgl_d;
    logic [2:0]             r_guard;
    logic [3:0]             r_pend;
    logic [CNT_W-1:0]       r_evt_cnt;
    logic                   r_ack;
    logic                   r_overrun;
    logic                   w_armed;
    logic                   w_edge;
    logic                   w_acc;
    logic                   w_full;
    logic [3:0]             w_pend_nxt;

    // Edges are masked until the sync chain and tgl_d hold post-reset samples,
    // so a level held high across reset is not mistaken for a transition.
    assign w_armed   = r_guard == GUARD_MAX;
    assign w_edge    = (r_sync[SYNC_STAGES-1] ^ r_tgl_d) & w_armed;
    assign evt_valid = r_pend != 4'd0;
    assign w_acc     = evt_valid & evt_ready;
    assign w_full    = r_pend == PEND_MAX;

    always_comb begin
        w_pend_nxt = r_pend;
        if (w_edge && !w_acc && !w_full)
            w_pend_nxt = r_pend + 4'd1;
        else if (w_acc && !w_edge)
            w_pend_nxt = r_pend - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_tgl_d   <= 1'b0;
            r_guard   <= 3'd0;
            r_pend    <= 4'd0;
            r_evt_cnt <= '0;
            r_ack     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], tgl_in};
            r_tgl_d   <= r_sync[SYNC_STAGES-1];
            r_guard   <= w_armed ? r_guard : r_guard + 3'd1;
            r_pend    <= w_pend_nxt;
            r_overrun <= w_edge & ~w_acc & w_full;
            if (w_acc) begin
                r_ack     <= ~r_ack;
                r_evt_cnt <= r_evt_cnt + 1'b1;
            end
        end
    end

    assign ack_tgl  = r_ack;
    assign overrun  = r_overrun;
    assign pend_cnt = r_pend;
    assign evt_cnt  = r_evt_cnt;
endmodule

// File: tb/tb_toggle_sync_rx.sv
// tb_toggle_sync_rx: directed checks of toggle_sync_rx (defaults, plus a CNT_W=2
// instance sharing the same stimulus for counter wrap).
module tb_toggle_sync_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tgl_in = 1'b1;
    logic       evt_ready = 1'b0;
    logic       evt_valid, ack_tgl, overrun;
    logic [3:0] pend_cnt;
    logic [7:0] evt_cnt;
    logic       b_valid, b_ack, b_ovr;
    logic [3:0] b_pend;
    logic [1:0] b_cnt;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    toggle_sync_rx dut (
        .clk(clk), .rst_n(rst_n), .tgl_in(tgl_in), .evt_ready(evt_ready),
        .evt_valid(evt_valid), .ack_tgl(ack_tgl), .overrun(overrun),
        .pend_cnt(pend_cnt), .evt_cnt(evt_cnt)
    );

    toggle_sync_rx #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .tgl_in(tgl_in), .evt_ready(evt_ready),
        .evt_valid(b_valid), .ack_tgl(b_ack), .overrun(b_ovr),
        .pend_cnt(b_pend), .evt_cnt(b_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, int'(evt_valid), 0);
        chk({tag, " pend"}, int'(pend_cnt), 0);
        chk({tag, " overrun"}, int'(overrun), 0);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // held reset with tgl_in=1
        step(2);
        chk_idle("reset");
        chk("reset ack", int'(ack_tgl), 0);
        chk("reset cnt", int'(evt_cnt), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk_idle("guard");
        end

        // single event with ready high: valid one cycle, two edges after capture
        evt_ready = 1'b1;
        tgl_in = 1'b0;
        step(1); chk("single v1", int'(evt_valid), 0);
        step(1); chk("single v2", int'(evt_valid), 0);
        step(1); chk("single v3", int'(evt_valid), 1);
        chk("single pend", int'(pend_cnt), 1);
        step(1); chk("single v4", int'(evt_valid), 0);
        chk("single ack", int'(ack_tgl), 1);
        chk("single cnt", int'(evt_cnt), 1);
        chk("single pend0", int'(pend_cnt), 0);

        // fill queue with ready low, fifth edge overruns
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tgl_in = ~tgl_in;
            step(3);
            chk($sformatf("fill ovr%0d", i), int'(overrun), (i == 4) ? 1 : 0);
            step(1);
            chk($sformatf("fill pend%0d", i), int'(pend_cnt), (i < 4) ? i + 1 : 4);
            chk($sformatf("fill ovr_off%0d", i), int'(overrun), 0);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk($sformatf("drain pend%0d", i), int'(pend_cnt), 3 - i);
            chk($sformatf("drain ack%0d", i), int'(ack_tgl), i % 2 == 0 ? 0 : 1);
            chk($sformatf("drain cnt%0d", i), int'(evt_cnt), 2 + i);
        end
        evt_ready = 1'b0;
        step(1);
        chk("drain empty", int'(evt_valid), 0);
        chk("drain hold cnt", int'(evt_cnt), 5);

        // refill to full, then edge coincides with an accept
        for (int i = 0; i < 4; i++) begin
            tgl_in = ~tgl_in;
            step(4);
        end
        chk("refill pend", int'(pend_cnt), 4);
        tgl_in = ~tgl_in;
        step(2);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("coinc pend", int'(pend_cnt), 4);
        chk("coinc ovr", int'(overrun), 0);
        chk("coinc ack", int'(ack_tgl), 0);
        chk("coinc cnt", int'(evt_cnt), 6);
        step(1);
        chk("coinc ovr2", int'(overrun), 0);
        chk("coinc pend2", int'(pend_cnt), 4);

        // accept one to reach 3, then reset with a transition mid-synchronizer
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("pre-rst pend", int'(pend_cnt), 3);
        chk("pre-rst cnt", int'(evt_cnt), 7);
        tgl_in = ~tgl_in;
        step(1);
        rst_n = 1'b0;
        #1;
        chk_idle("async rst");
        chk("async rst ack", int'(ack_tgl), 0);
        chk("async rst cnt", int'(evt_cnt), 0);
        step(3);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk_idle("post-rst");
        end
        chk("post-rst ack", int'(ack_tgl), 0);
        chk("post-rst cnt", int'(evt_cnt), 0);

        // five accepted events: 2-bit counter wraps 1,2,3,0,1
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tgl_in = ~tgl_in;
            step(4);
            chk($sformatf("wrap w2 cnt%0d", i), int'(b_cnt), (i + 1) % 4);
            chk($sformatf("wrap w8 cnt%0d", i), int'(evt_cnt), i + 1);
            chk($sformatf("wrap pend%0d", i), int'(pend_cnt), 0);
        end
        evt_ready = 1'b0;

        // ready while empty: no ack, no count
        evt_ready = 1'b1;
        step(3);
        chk("idle ready cnt", int'(evt_cnt), 5);
        chk("idle ready ack", int'(ack_tgl), 1);
        evt_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/toggle_sync_rx.md
Name: toggle_sync_rx

Overview:
- Receive end of the toggle-based single-bit CDC scheme, living entirely in the destination clock domain.
- Synchronizes an asynchronous toggle level from a source-domain flag register, detects each transition, and queues it as an event.
- Presents queued events to the local consumer on a valid/ready handshake and returns an acknowledge toggle that the source side synchronizes back.
- Together with the sender's toggle flop and its ack synchronizer, this closes the loop so source pulses can be issued without a fixed spacing rule.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on tgl_in; legal range 2..4.
- PEND_DEPTH, 4, maximum queued events before overrun; legal range 1..15.
- CNT_W, 8, width of the accepted-event counter.

Ports:
- clk  input  1  destination-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- tgl_in  input  1  toggle level from source domain, asynchronous to clk; each transition is one event.
- evt_ready  input  1  consumer can accept an event this cycle.
- evt_valid  output  1  at least one event is queued.
- ack_tgl  output  1  registered; toggles once per accepted event; returned to source domain.
- overrun  output  1  registered one-cycle pulse; an edge was dropped because the queue was full.
- pend_cnt  output  4  number of queued events, 0..PEND_DEPTH.
- evt_cnt  output  CNT_W  total accepted events, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, async):
  - All flops are 0: sync chain, tgl_d, pend_cnt, evt_cnt, ack_tgl, overrun, and the guard counter.
  - Therefore evt_valid=0, overrun=0, ack_tgl=0, pend_cnt=0, evt_cnt=0.
- Synchronizer: sync[0] samples tgl_in; sync[i] samples sync[i-1]; s = sync[SYNC_STAGES-1]; tgl_d registers s every cycle.
- Edge: edge = (s ^ tgl_d) & armed.
- Guard after reset release:
  - A guard counter counts SYNC_STAGES+1 clk edges; armed=1 once it saturates.
  - While armed=0, tgl_d still tracks s, but no edge is generated.
  - A tgl_in held at 1 across reset therefore produces no spurious event.
- Latency:
  - A tgl_in transition captured by sync[0] at clock edge k raises pend_cnt at edge k+SYNC_STAGES.
  - evt_valid is combinational from pend_cnt != 0, so it is high after edge k+SYNC_STAGES (k+2 with defaults).
- Accept: acc = evt_valid & evt_ready.
- Queue update, evaluated per cycle:
  - edge and not acc: pend_cnt+1 if pend_cnt < PEND_DEPTH; otherwise pend_cnt holds, the event is dropped, and overrun=1 next cycle.
  - acc and not edge: pend_cnt-1.
  - edge and acc together: pend_cnt unchanged, no overrun (even when full).
  - neither: hold.
- On acc: ack_tgl inverts and evt_cnt increments (wrapping from 2^CNT_W-1 to 0), both registered on the same edge.
- evt_ready while evt_valid=0: ignored; no ack, no count.
- overrun deasserts the cycle after it pulses unless another drop occurs.
- Glitch-free tgl_in is the sender's responsibility. One event per tgl_in transition is guaranteed only when transitions are separated by at least 2 clk periods; consecutive toggles closer than that may merge and lose events.
- Reset mid-operation: queued events, counts, and in-flight transitions are discarded; the guard re-arms.
- The ack_tgl reset value 0 matches the sender's flag reset value.

Test Plan:
- Reset release with tgl_in=1 held; run 10 clk -> evt_valid=0, pend_cnt=0, overrun=0 throughout.
- tgl_in 0->1 with evt_ready=1, SYNC_STAGES=2 -> evt_valid high exactly one cycle, 2 edges after capture; ack_tgl 0->1; evt_cnt=1; pend_cnt back to 0.
- evt_ready=0; toggle tgl_in 5 times spaced 4 clk (PEND_DEPTH=4) -> pend_cnt 1,2,3,4,4; one overrun pulse on the 5th; then evt_ready=1 for 4 cycles -> 4 accepts, ack_tgl toggles 4 times, evt_cnt=4.
- pend_cnt=4 (full), evt_ready=1, and a tgl_in edge arriving in the same cycle as an accept -> pend_cnt stays 4, no overrun.
- CNT_W=2; perform 5 accepted events -> evt_cnt sequence 1,2,3,0,1.
- Assert rst_n low while pend_cnt=3 and a tgl_in transition is mid-synchronizer; release -> all outputs 0, no event reported from the in-flight transition.
